// File: rtl/scoreboard_multi_pending.sv
// Per-warp GPR/predicate scoreboard: hazard check, destination reservation, multi-port writeback release.
// Build option: define SCOREBOARD_BYPASS_EN to credit same-cycle commits in the hazard check.
module scoreboard_multi_pending #(
  parameter int unsigned NUM_WARP   = 8,
  parameter int unsigned NUM_REG    = 64,
  parameter int unsigned NUM_PRED   = 32,
  parameter int unsigned NUM_COMMIT = 3,
  parameter int unsigned CNT_W      = 2,
  parameter bit          ALLOW_WAW  = 1'b0,
  localparam int unsigned WARP_W    = $clog2(NUM_WARP),
  localparam int unsigned REG_W     = $clog2(NUM_REG),
  localparam int unsigned PRED_W    = $clog2(NUM_PRED)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall_i,
  input  logic                         chk_valid_i,
  input  logic [WARP_W-1:0]            chk_warp_i,
  input  logic [PRED_W-1:0]            chk_pred_i,
  input  logic [3*REG_W-1:0]           chk_src_i,
  input  logic [2:0]                   chk_src_valid_i,
  input  logic [REG_W-1:0]             chk_dest_i,
  input  logic                         chk_dest_valid_i,
  input  logic                         chk_dest_pred_i,
  input  logic                         issue_i,
  output logic                         ready_o,
  input  logic [NUM_COMMIT-1:0]        cmt_valid_i,
  input  logic [NUM_COMMIT*WARP_W-1:0] cmt_warp_i,
  input  logic [NUM_COMMIT*REG_W-1:0]  cmt_reg_i,
  input  logic [NUM_COMMIT-1:0]        cmt_pred_i,
  input  logic                         flush_i,
  input  logic [WARP_W-1:0]            flush_warp_i,
  output logic                         err_o,
  output logic [NUM_WARP-1:0]          pending_o
);

  localparam int unsigned NUM_ENT = NUM_REG + NUM_PRED;
  localparam int unsigned ENT_W   = $clog2(NUM_ENT);
  localparam int unsigned ACC_W   = CNT_W + $clog2(NUM_COMMIT + 2);
  localparam int unsigned N_LK    = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // GPRs occupy entries [0, NUM_REG); predicates follow them.
  function automatic logic [ENT_W-1:0] ent_of(input logic is_pred, input logic [REG_W-1:0] idx);
    if (is_pred) return ENT_W'(NUM_REG) + ENT_W'(idx[PRED_W-1:0]);
    return ENT_W'(idx);
  endfunction

  logic [CNT_W-1:0] cnt_q [NUM_WARP][NUM_ENT];
  logic [CNT_W-1:0] cnt_d [NUM_WARP][NUM_ENT];
  logic [NUM_WARP-1:0] pend_d;
  logic err_d;

  logic [NUM_COMMIT-1:0]             cmt_trk;
  logic [NUM_COMMIT-1:0][WARP_W-1:0] cmt_w;
  logic [NUM_COMMIT-1:0][REG_W-1:0]  cmt_r;
  logic [NUM_COMMIT-1:0][ENT_W-1:0]  cmt_e;

  logic [N_LK-1:0][ENT_W-1:0] lk_ent;
  logic [N_LK-1:0][CNT_W-1:0] lk_cnt;
`ifdef SCOREBOARD_BYPASS_EN
  logic [N_LK-1:0][ACC_W-1:0] credit;
`endif

  logic       pred_ok, dest_trk, dest_ok, reserve;
  logic [2:0] src_ok;
  logic [ACC_W-1:0] acc, dec;

  // Commit port decode; predicate 0 is never tracked so its writebacks are dropped.
  always_comb begin
    for (int p = 0; p < NUM_COMMIT; p++) begin
      cmt_w[p]   = cmt_warp_i[p*WARP_W +: WARP_W];
      cmt_r[p]   = cmt_reg_i[p*REG_W +: REG_W];
      cmt_e[p]   = ent_of(cmt_pred_i[p], cmt_r[p]);
      cmt_trk[p] = cmt_valid_i[p] && !(cmt_pred_i[p] && (cmt_r[p][PRED_W-1:0] == '0));
    end
  end

  // Lookups: 0 = guard predicate, 1..3 = sources, 4 = destination.
  always_comb begin
    lk_ent[0] = ENT_W'(NUM_REG) + ENT_W'(chk_pred_i);
    for (int s = 0; s < 3; s++) lk_ent[s+1] = ENT_W'(chk_src_i[s*REG_W +: REG_W]);
    lk_ent[4] = ent_of(chk_dest_pred_i, chk_dest_i);
  end

  always_comb begin
`ifdef SCOREBOARD_BYPASS_EN
    credit = '0;
`endif
    for (int i = 0; i < N_LK; i++) begin
`ifdef SCOREBOARD_BYPASS_EN
      for (int p = 0; p < NUM_COMMIT; p++)
        if (cmt_trk[p] && cmt_w[p] == chk_warp_i && cmt_e[p] == lk_ent[i])
          credit[i] = credit[i] + ACC_W'(1);
      lk_cnt[i] = (ACC_W'(cnt_q[chk_warp_i][lk_ent[i]]) > credit[i])
                ? CNT_W'(ACC_W'(cnt_q[chk_warp_i][lk_ent[i]]) - credit[i]) : '0;
`else
      lk_cnt[i] = cnt_q[chk_warp_i][lk_ent[i]];
`endif
    end
  end

  always_comb begin
    pred_ok = (chk_pred_i == '0) || (lk_cnt[0] == '0);
    for (int s = 0; s < 3; s++) src_ok[s] = !chk_src_valid_i[s] || (lk_cnt[s+1] == '0);
    dest_trk = chk_dest_valid_i && !(chk_dest_pred_i && (chk_dest_i[PRED_W-1:0] == '0));
    if (!dest_trk)      dest_ok = 1'b1;
    else if (ALLOW_WAW) dest_ok = (lk_cnt[4] != CNT_MAX);
    else                dest_ok = (lk_cnt[4] == '0);
    ready_o = chk_valid_i && pred_ok && (&src_ok) && dest_ok;
    reserve = ready_o && issue_i && !stall_i && dest_trk;
  end

  // Counter update: +reserve -commits, clamped; flush wins over everything for its warp.
  always_comb begin
    err_d  = err_o;
    pend_d = '0;
    acc    = '0;
    dec    = '0;
    for (int w = 0; w < NUM_WARP; w++) begin
      for (int e = 0; e < NUM_ENT; e++) begin
        acc = ACC_W'(cnt_q[w][e]);
        dec = '0;
        if (reserve && chk_warp_i == WARP_W'(w) && lk_ent[4] == ENT_W'(e)) acc = acc + ACC_W'(1);
        for (int p = 0; p < NUM_COMMIT; p++)
          if (cmt_trk[p] && cmt_w[p] == WARP_W'(w) && cmt_e[p] == ENT_W'(e)) dec = dec + ACC_W'(1);
        if (flush_i && flush_warp_i == WARP_W'(w)) begin
          cnt_d[w][e] = '0;
        end else if (dec > acc) begin
          cnt_d[w][e] = '0;
          err_d       = 1'b1;
        end else if ((acc - dec) > ACC_W'(CNT_MAX)) begin
          cnt_d[w][e] = CNT_MAX;
        end else begin
          cnt_d[w][e] = CNT_W'(acc - dec);
        end
        pend_d[w] = pend_d[w] | (cnt_d[w][e] != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '{default: '0};
      err_o     <= 1'b0;
      pending_o <= '0;
    end else begin
      cnt_q     <= cnt_d;
      err_o     <= err_d;
      pending_o <= pend_d;
    end
  end

endmodule

// File: tb/tb_scoreboard_multi_pending.sv
// Scoreboard bench for scoreboard_multi_pending: two DUTs (ALLOW_WAW=0 and 1) on shared stimulus,
// expectations from a per-register pending-count model pushed to a queue and checked by a monitor.
module tb_scoreboard_multi_pending;
  localparam int NW = 8, NR = 64, NP = 32, NC = 3, CMAX = 3;
  localparam int WW = 3, RW = 6, PW = 5;

  logic clk, reset;
  logic stall, chk_valid, chk_dest_valid, chk_dest_pred, issue, flush;
  logic [WW-1:0] chk_warp, flush_warp;
  logic [PW-1:0] chk_pred;
  logic [3*RW-1:0] chk_src;
  logic [2:0] chk_src_valid;
  logic [RW-1:0] chk_dest;
  logic [NC-1:0] cmt_valid, cmt_pred;
  logic [NC*WW-1:0] cmt_warp;
  logic [NC*RW-1:0] cmt_reg;
  logic ready0, ready1, err0, err1;
  logic [NW-1:0] pend0, pend1;

  scoreboard_multi_pending #(.ALLOW_WAW(1'b0)) u_waw0 (
    .clk(clk), .reset(reset), .stall_i(stall), .chk_valid_i(chk_valid), .chk_warp_i(chk_warp),
    .chk_pred_i(chk_pred), .chk_src_i(chk_src), .chk_src_valid_i(chk_src_valid), .chk_dest_i(chk_dest),
    .chk_dest_valid_i(chk_dest_valid), .chk_dest_pred_i(chk_dest_pred), .issue_i(issue), .ready_o(ready0),
    .cmt_valid_i(cmt_valid), .cmt_warp_i(cmt_warp), .cmt_reg_i(cmt_reg), .cmt_pred_i(cmt_pred),
    .flush_i(flush), .flush_warp_i(flush_warp), .err_o(err0), .pending_o(pend0));

  scoreboard_multi_pending #(.ALLOW_WAW(1'b1)) u_waw1 (
    .clk(clk), .reset(reset), .stall_i(stall), .chk_valid_i(chk_valid), .chk_warp_i(chk_warp),
    .chk_pred_i(chk_pred), .chk_src_i(chk_src), .chk_src_valid_i(chk_src_valid), .chk_dest_i(chk_dest),
    .chk_dest_valid_i(chk_dest_valid), .chk_dest_pred_i(chk_dest_pred), .issue_i(issue), .ready_o(ready1),
    .cmt_valid_i(cmt_valid), .cmt_warp_i(cmt_warp), .cmt_reg_i(cmt_reg), .cmt_pred_i(cmt_pred),
    .flush_i(flush), .flush_warp_i(flush_warp), .err_o(err1), .pending_o(pend1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic r0, r1, e0, e1;
    logic [NW-1:0] p0, p1;
    logic [31:0] cyc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int gpr[2][NW][NR];
  int prd[2][NW][NP];
  bit merr[2];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, expv);
    end
  endfunction

  // ---------------- reference model: pending-write count per register ----------------
  function automatic int get(int i, int w, bit isp, int x);
    return isp ? prd[i][w][x] : gpr[i][w][x];
  endfunction

  function automatic void add(int i, int w, bit isp, int x, int d);
    if (isp) prd[i][w][x] += d; else gpr[i][w][x] += d;
  endfunction

  function automatic int cmt_idx(int p, bit isp);
    int r = int'(cmt_reg[p*RW +: RW]);
    return isp ? r % NP : r;
  endfunction

  function automatic int hits(int w, bit isp, int x);
    int k = 0;
    for (int p = 0; p < NC; p++)
      if (cmt_valid[p] && int'(cmt_warp[p*WW +: WW]) == w && cmt_pred[p] == isp && cmt_idx(p, isp) == x) k++;
    return k;
  endfunction

  function automatic int eff(int i, int w, bit isp, int x);
    int c = get(i, w, isp, x);
`ifdef SCOREBOARD_BYPASS_EN
    c -= hits(w, isp, x);
    if (c < 0) c = 0;
`endif
    return c;
  endfunction

  function automatic bit dest_tracked();
    return chk_dest_valid && !(chk_dest_pred && chk_dest[PW-1:0] == '0);
  endfunction

  function automatic int dest_idx();
    return chk_dest_pred ? int'(chk_dest[PW-1:0]) : int'(chk_dest);
  endfunction

  function automatic bit exp_ready(int i);
    int w = int'(chk_warp);
    int c;
    if (!chk_valid) return 1'b0;
    if (chk_pred != '0 && eff(i, w, 1'b1, int'(chk_pred)) != 0) return 1'b0;
    for (int s = 0; s < 3; s++)
      if (chk_src_valid[s] && eff(i, w, 1'b0, int'(chk_src[s*RW +: RW])) != 0) return 1'b0;
    if (dest_tracked()) begin
      c = eff(i, w, chk_dest_pred, dest_idx());
      if (i == 0 ? (c != 0) : (c >= CMAX)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [NW-1:0] pend_vec(int i);
    logic [NW-1:0] v = '0;
    for (int w = 0; w < NW; w++) begin
      for (int x = 0; x < NR; x++) if (gpr[i][w][x] != 0) v[w] = 1'b1;
      for (int x = 0; x < NP; x++) if (prd[i][w][x] != 0) v[w] = 1'b1;
    end
    return v;
  endfunction

  function automatic void model_step(int i, bit rdy);
    int fw = flush ? int'(flush_warp) : -1;
    if (rdy && issue && !stall && dest_tracked() && int'(chk_warp) != fw)
      add(i, int'(chk_warp), chk_dest_pred, dest_idx(), 1);
    for (int p = 0; p < NC; p++) begin
      int w = int'(cmt_warp[p*WW +: WW]);
      int x = cmt_idx(p, cmt_pred[p]);
      if (cmt_valid[p] && !(cmt_pred[p] && x == 0) && w != fw) add(i, w, cmt_pred[p], x, -1);
    end
    for (int w = 0; w < NW; w++) begin
      for (int x = 0; x < NR; x++) begin
        if (gpr[i][w][x] < 0) begin gpr[i][w][x] = 0; merr[i] = 1'b1; end
        if (gpr[i][w][x] > CMAX) gpr[i][w][x] = CMAX;
        if (w == fw) gpr[i][w][x] = 0;
      end
      for (int x = 0; x < NP; x++) begin
        if (prd[i][w][x] < 0) begin prd[i][w][x] = 0; merr[i] = 1'b1; end
        if (prd[i][w][x] > CMAX) prd[i][w][x] = CMAX;
        if (w == fw) prd[i][w][x] = 0;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      merr[i] = 1'b0;
      for (int w = 0; w < NW; w++) begin
        for (int x = 0; x < NR; x++) gpr[i][w][x] = 0;
        for (int x = 0; x < NP; x++) prd[i][w][x] = 0;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    stall = 0; chk_valid = 0; chk_warp = '0; chk_pred = '0; chk_src = '0; chk_src_valid = '0;
    chk_dest = '0; chk_dest_valid = 0; chk_dest_pred = 0; issue = 0;
    cmt_valid = '0; cmt_warp = '0; cmt_reg = '0; cmt_pred = '0; flush = 0; flush_warp = '0;
  endtask

  task automatic cand(int w, int pred, int s1, bit v1, int dest, bit dv, bit dp, bit iss);
    chk_valid = 1'b1; chk_warp = WW'(w); chk_pred = PW'(pred);
    chk_src = '0; chk_src[RW-1:0] = RW'(s1); chk_src_valid = {2'b00, v1};
    chk_dest = RW'(dest); chk_dest_valid = dv; chk_dest_pred = dp; issue = iss;
  endtask

  task automatic set_cmt(int p, int w, int r, bit isp);
    cmt_valid[p] = 1'b1; cmt_warp[p*WW +: WW] = WW'(w); cmt_reg[p*RW +: RW] = RW'(r); cmt_pred[p] = isp;
  endtask

  // Push this cycle's expectation, then advance the model across the clock edge.
  task automatic step();
    exp_t e;
    e.r0 = exp_ready(0); e.r1 = exp_ready(1);
    e.e0 = merr[0]; e.e1 = merr[1];
    e.p0 = pend_vec(0); e.p1 = pend_vec(1);
    e.cyc = 32'(cyc);
    q.push_back(e);
    @(posedge clk);
    model_step(0, e.r0);
    model_step(1, e.r1);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    reset = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        cyc = int'(e.cyc);
        chk("ready_waw0", 32'(ready0), 32'(e.r0));
        chk("ready_waw1", 32'(ready1), 32'(e.r1));
        chk("err_waw0", 32'(err0), 32'(e.e0));
        chk("err_waw1", 32'(err1), 32'(e.e1));
        chk("pend_waw0", 32'(pend0), 32'(e.p0));
        chk("pend_waw1", 32'(pend1), 32'(e.p1));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    idle();
    model_reset();
    do_reset();
    chk("rst_err0", 32'(err0), 0);
    chk("rst_err1", 32'(err1), 0);
    chk("rst_pend0", 32'(pend0), 0);
    chk("rst_pend1", 32'(pend1), 0);

    // warp2 candidate on clean state
    idle(); cand(2, 0, 5, 1, 0, 0, 0, 0); #1 chk("t1_ready", 32'(ready0), 1); step();

    // RAW on w2 R5, released through port 1
    idle(); cand(2, 0, 0, 0, 5, 1, 0, 1); step();
    idle(); cand(2, 0, 5, 1, 0, 0, 0, 0); #1 chk("t2_busy0", 32'(ready0), 0); chk("t2_busy1", 32'(ready1), 0); step();
    idle(); cand(2, 0, 5, 1, 0, 0, 0, 0); set_cmt(1, 2, 5, 0);
`ifdef SCOREBOARD_BYPASS_EN
    #1 chk("t2_bypass", 32'(ready0), 1);
`else
    #1 chk("t2_nobypass", 32'(ready0), 0);
`endif
    step();
    idle(); cand(2, 0, 5, 1, 0, 0, 0, 0); #1 chk("t2_freed", 32'(ready0), 1); step();

    // stall blocks reservation, commit still drains
    idle(); cand(4, 0, 0, 0, 11, 1, 0, 1); step();
    idle(); stall = 1; cand(4, 0, 0, 0, 10, 1, 0, 1); set_cmt(0, 4, 11, 0); step();
    idle(); cand(4, 0, 10, 1, 0, 0, 0, 0); chk_src[RW +: RW] = RW'(11); chk_src_valid = 3'b011;
    #1 chk("t4_stall0", 32'(ready0), 1); chk("t4_stall1", 32'(ready1), 1); step();

    // predicate guard, then flush racing a reservation
    idle(); cand(3, 0, 0, 0, 4, 1, 1, 1); step();
    idle(); cand(3, 4, 0, 0, 0, 0, 0, 0); #1 chk("t5_pred_busy", 32'(ready0), 0); step();
    idle(); cand(3, 0, 0, 0, 0, 0, 0, 0); #1 chk("t5_pred0", 32'(ready0), 1); step();
    idle(); flush = 1; flush_warp = 3'd3; cand(3, 0, 0, 0, 1, 1, 0, 1); step();
    idle(); cand(3, 4, 0, 0, 0, 0, 0, 0);
    #1 chk("t5_flush_pend0", 32'(pend0[3]), 0); chk("t5_flush_pend1", 32'(pend1[3]), 0);
    chk("t5_flush_ready", 32'(ready0), 1); step();

    // underflow is sticky
    idle(); set_cmt(2, 1, 9, 0); step();
    idle(); #1 chk("t6_err0", 32'(err0), 1); chk("t6_err1", 32'(err1), 1);
    repeat (3) step();
    #1 chk("t6_sticky", 32'(err0), 1);

    // WAW depth on w0 R7 and double commit
    idle(); cand(0, 0, 0, 0, 7, 1, 0, 1); repeat (3) step();
    idle(); cand(0, 0, 0, 0, 7, 1, 0, 0); #1 chk("t3_full1", 32'(ready1), 0); chk("t3_full0", 32'(ready0), 0); step();
    idle(); set_cmt(0, 0, 7, 0); set_cmt(1, 0, 7, 0); step();
    idle(); cand(0, 0, 0, 0, 7, 1, 0, 0); #1 chk("t3_room1", 32'(ready1), 1); chk("t3_room0", 32'(ready0), 1); step();

    do_reset();
    chk("rst2_err0", 32'(err0), 0);
    chk("rst2_err1", 32'(err1), 0);

    // randomized traffic on a narrow register window to force collisions
    for (int n = 0; n < 1500; n++) begin
      idle();
      stall = ($urandom_range(0, 7) == 0);
      chk_valid = ($urandom_range(0, 3) != 0);
      chk_warp = WW'($urandom_range(0, 3));
      chk_pred = PW'($urandom_range(0, 3));
      for (int s = 0; s < 3; s++) chk_src[s*RW +: RW] = RW'($urandom_range(0, 7));
      chk_src_valid = 3'($urandom);
      chk_dest = RW'($urandom_range(0, 7));
      chk_dest_valid = ($urandom_range(0, 3) != 0);
      chk_dest_pred = ($urandom_range(0, 3) == 0);
      issue = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      flush_warp = WW'($urandom_range(0, 3));
      for (int p = 0; p < NC; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          int w = $urandom_range(0, 3);
          bit isp = ($urandom_range(0, 3) == 0);
          int x = isp ? $urandom_range(1, 3) : $urandom_range(0, 7);
          int avail = (get(0, w, isp, x) < get(1, w, isp, x)) ? get(0, w, isp, x) : get(1, w, isp, x);
          if (avail - hits(w, isp, x) > 0) set_cmt(p, w, x, isp);
        end
      end
      step();
    end

    idle();
    step();
    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
